aidc_lite_comp_drv: RTL and testbench

AIDC_LITE_COMP_DRV -- requirements
Module: aidc_lite_comp_drv

---
 rtl/aidc_lite_pkg.sv | 48 ++++
 rtl/apb_intf.sv | 25 ++
 rtl/aidc_lite_comp_drv.sv | 196 +++++++++++++++++++
 tb/tb_aidc_lite_comp_drv.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_pkg.sv
// aidc_lite_pkg
//   Shared definitions for the AIDC-lite config block and its drivers:
//   register offsets, control encodings, driver FSM states and the
//   transfer-step encoding. No ports.
package aidc_lite_pkg;

  // Register offsets relative to the config block base address
  localparam logic [31:0] REG_SRC_OFS  = 32'h0000_0000;
  localparam logic [31:0] REG_DST_OFS  = 32'h0000_0004;
  localparam logic [31:0] REG_LEN_OFS  = 32'h0000_0008;
  localparam logic [31:0] REG_CTRL_OFS = 32'h0000_000C;

  // CTRL write value that launches a job; STATUS bit 0 reports done
  localparam logic [31:0] CTRL_START   = 32'h0000_0001;

  // Length is carried in 128-byte units in bits [31:7]
  localparam int unsigned LEN_W        = 25;
  localparam int unsigned LEN_SHIFT    = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_GAP,
    ST_CMPL
  } drv_state_e;

  typedef enum logic [2:0] {
    STEP_SRC    = 3'd0,
    STEP_DST    = 3'd1,
    STEP_LEN    = 3'd2,
    STEP_START  = 3'd3,
    STEP_STATUS = 3'd4
  } step_e;

  // Register offset addressed by each step
  function automatic logic [31:0] step_offset(input step_e s);
    logic [31:0] ofs;
    case (s)
      STEP_SRC: ofs = REG_SRC_OFS;
      STEP_DST: ofs = REG_DST_OFS;
      STEP_LEN: ofs = REG_LEN_OFS;
      default:  ofs = REG_CTRL_OFS;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/apb_intf.sv
// APB_INTF
//   Plain APB3 signal bundle (no clock/reset; those are routed separately).
//   master modport: drives paddr/psel/penable/pwrite/pwdata,
//                   samples prdata/pready/pslverr.
//   slave modport : the mirror image.
interface APB_INTF;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/aidc_lite_comp_drv.sv
// aidc_lite_comp_drv
//   Programs one AIDC-lite job into the config block over APB: writes SRC,
//   DST, LEN and START, then polls STATUS bit 0 with POLL_GAP idle cycles
//   before every read until done, a slave error, or MAX_POLLS reads.
// Parameters
//   BASE_ADDR  APB base address of the config block
//   POLL_GAP   idle cycles before each status read (1..255)
//   MAX_POLLS  status reads before the job is failed with a timeout error
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   apb_if         APB master
//   req_valid_i    job request        / req_ready_o  accepted when both high
//   req_src_i      source address     / req_dst_i    destination address
//   req_len_i      length in 128 B units (lands in LEN[31:7])
//   cmpl_valid_o   job finished       / cmpl_ready_i completion consumed
//   cmpl_err_o     error flag, valid with cmpl_valid_o
//   busy_o         high whenever the driver is not idle
module aidc_lite_comp_drv
  import aidc_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  APB_INTF.master           apb_if,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_src_i,
  input  logic [31:0]       req_dst_i,
  input  logic [LEN_W-1:0]  req_len_i,
  output logic              cmpl_valid_o,
  input  logic              cmpl_ready_i,
  output logic              cmpl_err_o,
  output logic              busy_o
);

  localparam int unsigned       PW        = $clog2(MAX_POLLS) + 1;
  localparam logic [7:0]        GAP_LAST  = 8'(POLL_GAP - 1);
  localparam logic [PW-1:0]     POLL_LAST = PW'(MAX_POLLS - 1);

  drv_state_e        state_q, state_d;
  step_e             step_q,  step_d;
  logic [7:0]        gap_q,   gap_d;
  logic [PW-1:0]     poll_q,  poll_d;
  logic              err_q,   err_d;
  logic [31:0]       src_q, dst_q;
  logic [LEN_W-1:0]  len_q;

  logic              accept;
  logic              apb_psel, apb_penable, apb_pwrite;
  logic [31:0]       apb_paddr, apb_pwdata, step_wdata;

  // Only the done bit of STATUS carries meaning
  logic              unused_prdata;
  assign unused_prdata = ^apb_if.prdata[31:1];

  assign accept = req_valid_i && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_SRC;
      gap_q   <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      if (accept) begin
        src_q <= req_src_i;
        dst_q <= req_dst_i;
        len_q <= req_len_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_SETUP;
          step_d  = STEP_SRC;
          gap_d   = '0;
          poll_d  = '0;
          err_d   = 1'b0;
        end
      end

      ST_SETUP: state_d = ST_ACCESS;

      ST_ACCESS: begin
        // pslverr is only meaningful on the completing cycle
        if (apb_if.pready) begin
          if (apb_if.pslverr) begin
            state_d = ST_CMPL;
            err_d   = 1'b1;
          end else begin
            case (step_q)
              STEP_SRC, STEP_DST, STEP_LEN: begin
                step_d  = step_e'(step_q + 3'd1);
                state_d = ST_SETUP;
              end
              STEP_START: begin
                step_d  = STEP_STATUS;
                poll_d  = '0;
                gap_d   = '0;
                state_d = ST_GAP;
              end
              default: begin
                if (apb_if.prdata[0]) begin
                  state_d = ST_CMPL;
                  err_d   = 1'b0;
                end else if (poll_q == POLL_LAST) begin
                  state_d = ST_CMPL;
                  err_d   = 1'b1;
                end else begin
                  poll_d  = poll_q + PW'(1);
                  gap_d   = '0;
                  state_d = ST_GAP;
                end
              end
            endcase
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_SETUP;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      ST_CMPL: begin
        if (cmpl_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (step_q)
      STEP_SRC:   step_wdata = src_q;
      STEP_DST:   step_wdata = dst_q;
      STEP_LEN:   step_wdata = {len_q, {LEN_SHIFT{1'b0}}};
      STEP_START: step_wdata = CTRL_START;
      default:    step_wdata = '0;
    endcase
  end

  // APB outputs decode straight from registered state, so they hold
  // steady across every wait cycle of an access.
  always_comb begin
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    apb_paddr   = '0;
    apb_pwdata  = '0;
    if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
      apb_psel    = 1'b1;
      apb_penable = (state_q == ST_ACCESS);
      apb_paddr   = BASE_ADDR + step_offset(step_q);
      apb_pwrite  = (step_q != STEP_STATUS);
      apb_pwdata  = apb_pwrite ? step_wdata : '0;
    end
  end

  assign apb_if.psel    = apb_psel;
  assign apb_if.penable = apb_penable;
  assign apb_if.pwrite  = apb_pwrite;
  assign apb_if.paddr   = apb_paddr;
  assign apb_if.pwdata  = apb_pwdata;

  assign req_ready_o  = rst_n && (state_q == ST_IDLE);
  assign cmpl_valid_o = (state_q == ST_CMPL);
  assign cmpl_err_o   = (state_q == ST_CMPL) && err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aidc_lite_comp_drv.sv
module tb_aidc_lite_comp_drv;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam int          GAP_A  = 16;
  localparam int          MAXP_A = 1024;
  localparam logic [31:0] BASE_B = 32'h4000_0100;
  localparam int          GAP_B  = 3;
  localparam int          MAXP_B = 4;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_q = 1'b0;
  logic sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_src = '0;
  logic [31:0] req_dst = '0;
  logic [24:0] req_len = '0;
  logic        cmpl_ready = 1'b0;
  logic        s_pready = 1'b1;
  logic        s_pslverr = 1'b0;
  logic [31:0] s_prdata = '0;

  logic ready_a, ready_b, cv_a, cv_b, ce_a, ce_b, busy_a, busy_b;

  APB_INTF apb_a ();
  APB_INTF apb_b ();

  assign apb_a.prdata = s_prdata;
  assign apb_a.pready = s_pready;
  assign apb_a.pslverr = s_pslverr;
  assign apb_b.prdata = s_prdata;
  assign apb_b.pready = s_pready;
  assign apb_b.pslverr = s_pslverr;

  aidc_lite_comp_drv #(.BASE_ADDR(BASE_A), .POLL_GAP(GAP_A), .MAX_POLLS(MAXP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .apb_if(apb_a.master),
    .req_valid_i(req_valid && !sel), .req_ready_o(ready_a),
    .req_src_i(req_src), .req_dst_i(req_dst), .req_len_i(req_len),
    .cmpl_valid_o(cv_a), .cmpl_ready_i(cmpl_ready && !sel), .cmpl_err_o(ce_a),
    .busy_o(busy_a)
  );

  aidc_lite_comp_drv #(.BASE_ADDR(BASE_B), .POLL_GAP(GAP_B), .MAX_POLLS(MAXP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .apb_if(apb_b.master),
    .req_valid_i(req_valid && sel), .req_ready_o(ready_b),
    .req_src_i(req_src), .req_dst_i(req_dst), .req_len_i(req_len),
    .cmpl_valid_o(cv_b), .cmpl_ready_i(cmpl_ready && sel), .cmpl_err_o(ce_b),
    .busy_o(busy_b)
  );

  // View of whichever driver is under test
  logic        m_psel, m_penable, m_pwrite, m_req_ready, m_cmpl_valid, m_cmpl_err, m_busy;
  logic [31:0] m_paddr, m_pwdata;
  assign m_psel       = sel ? apb_b.psel    : apb_a.psel;
  assign m_penable    = sel ? apb_b.penable : apb_a.penable;
  assign m_pwrite     = sel ? apb_b.pwrite  : apb_a.pwrite;
  assign m_paddr      = sel ? apb_b.paddr   : apb_a.paddr;
  assign m_pwdata     = sel ? apb_b.pwdata  : apb_a.pwdata;
  assign m_req_ready  = sel ? ready_b : ready_a;
  assign m_cmpl_valid = sel ? cv_b : cv_a;
  assign m_cmpl_err   = sel ? ce_b : ce_a;
  assign m_busy       = sel ? busy_b : busy_a;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) begin
    rst_q <= rst_n;
    cyc   <= cyc + 1;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Slave behaviour knobs
  int stall_idx = -1, stall_n = 0, err_idx = -1, done_after = 0;

  // Model state
  xfer_t       exp_q[$];
  xfer_t       hd;
  logic        e_busy = 1'b0, e_cmpl = 1'b0, e_err = 1'b0;
  logic [31:0] mb_base;
  int          mb_gap, maxp, n_exp;
  int          xfer_idx, reads, idle_run, acc_len;
  int          accept_cyc, start_acc_cyc;
  logic [31:0] wd [4];
  logic        prev_setup = 1'b0, prev_acc = 1'b0, prev_wr;
  logic [31:0] prev_addr, prev_wdata;
  logic        setup, acc, busy_now;

  // Observations for the literal checks
  logic [31:0] obs_wr[$];
  int          obs_rd;
  int          acc_log[$];
  int          gap_log[$];

  always @(negedge clk) begin
    busy_now  = e_busy;
    s_pready  = 1'b1;
    s_pslverr = 1'b0;
    s_prdata  = 32'h5A5A_5A5A;
    if (!rst_q) begin
      exp_q.delete();
      e_busy = 1'b0; e_cmpl = 1'b0; e_err = 1'b0; busy_now = 1'b0;
      prev_setup = 1'b0; prev_acc = 1'b0;
      chk("rst_psel", m_psel, 0);
      chk("rst_penable", m_penable, 0);
      chk("rst_paddr", m_paddr, 0);
      chk("rst_pwrite", m_pwrite, 0);
      chk("rst_pwdata", m_pwdata, 0);
      chk("rst_cmpl_valid", m_cmpl_valid, 0);
      chk("rst_cmpl_err", m_cmpl_err, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_req_ready", m_req_ready, rst_n);
    end else begin
      setup = m_psel && !m_penable;
      acc   = m_psel && m_penable;
      chk("busy", m_busy, e_busy);
      chk("req_ready", m_req_ready, !e_busy && rst_n);
      chk("cmpl_valid", m_cmpl_valid, e_cmpl);
      if (e_cmpl) chk("cmpl_err", m_cmpl_err, e_err);
      if (!m_psel) chk("penable_without_psel", m_penable, 0);
      if (!e_busy) begin
        chk("idle_psel", m_psel, 0);
        chk("idle_paddr", m_paddr, 0);
        chk("idle_pwrite", m_pwrite, 0);
        chk("idle_pwdata", m_pwdata, 0);
      end
      if (prev_setup) chk("setup_then_access", acc, 1);
      if (acc) chk("access_has_setup", prev_setup || prev_acc, 1);
      if (acc && prev_acc) begin
        chk("hold_paddr", m_paddr, prev_addr);
        chk("hold_pwdata", m_pwdata, prev_wdata);
        chk("hold_pwrite", m_pwrite, prev_wr);
      end
      if (setup) begin
        chk("setup_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("paddr", m_paddr, exp_q[0].addr);
          chk("pwrite", m_pwrite, !exp_q[0].rd);
          if (!exp_q[0].rd) chk("pwdata", m_pwdata, exp_q[0].data);
          chk("idle_before_setup", idle_run, exp_q[0].rd ? mb_gap : 0);
          if (exp_q[0].rd) gap_log.push_back(idle_run);
        end
        idle_run = 0;
        acc_len  = 0;
      end
      if (e_busy && !m_psel && !e_cmpl) idle_run++;
      if (acc) begin
        acc_len++;
        if (acc_len == 1 && exp_q.size() != 0 && !exp_q[0].rd && exp_q[0].addr == mb_base + 32'hC)
          start_acc_cyc = cyc;
        if (xfer_idx == stall_idx && acc_len <= stall_n) begin
          s_pready  = 1'b0;
          s_pslverr = 1'b1;
          s_prdata  = 32'hFFFF_FFFF;
        end else begin
          s_pslverr = (xfer_idx == err_idx);
          s_prdata  = (reads >= done_after) ? 32'h0000_0001 : 32'hFFFF_FFFE;
          chk("xfer_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            hd = exp_q.pop_front();
            chk("access_cycles", acc_len, (xfer_idx == stall_idx) ? stall_n + 1 : 1);
            acc_log.push_back(acc_len);
            if (hd.rd) begin
              reads++;
              obs_rd++;
            end else begin
              obs_wr.push_back(m_pwdata);
            end
            xfer_idx++;
            if (exp_q.size() == 0) e_cmpl = 1'b1;
          end
        end
      end
      prev_setup = setup;
      prev_acc   = acc;
      prev_addr  = m_paddr;
      prev_wdata = m_pwdata;
      prev_wr    = m_pwrite;
      if (e_cmpl && cmpl_ready) begin
        e_cmpl = 1'b0;
        e_busy = 1'b0;
      end
    end
    // A request seen here is taken at the coming edge only if the driver was idle
    if (req_valid && !busy_now && rst_n) begin
      mb_base = sel ? BASE_B : BASE_A;
      mb_gap  = sel ? GAP_B : GAP_A;
      maxp    = sel ? MAXP_B : MAXP_A;
      wd[0] = req_src;
      wd[1] = req_dst;
      wd[2] = {req_len, 7'b0};
      wd[3] = 32'h1;
      if (err_idx >= 0) begin
        n_exp = err_idx + 1; e_err = 1'b1;
      end else if (done_after < maxp) begin
        n_exp = 4 + done_after + 1; e_err = 1'b0;
      end else begin
        n_exp = 4 + maxp; e_err = 1'b1;
      end
      exp_q.delete();
      for (int j = 0; j < n_exp; j++) begin
        hd.rd   = (j >= 4);
        hd.addr = mb_base + ((j >= 4) ? 32'hC : 32'(4 * j));
        hd.data = (j < 4) ? wd[j] : 32'h0;
        exp_q.push_back(hd);
      end
      e_busy = 1'b1; e_cmpl = 1'b0;
      xfer_idx = 0; reads = 0; idle_run = 0; acc_len = 0;
      obs_wr.delete(); obs_rd = 0; acc_log.delete(); gap_log.delete();
      accept_cyc = cyc; start_acc_cyc = -1;
    end
  end

  task automatic cfg(input int si, input int sn, input int ei, input int da);
    stall_idx = si; stall_n = sn; err_idx = ei; done_after = da;
  endtask

  task automatic issue(input logic [31:0] src, input logic [31:0] dst, input logic [24:0] len);
    logic got;
    got = 1'b0;
    req_src = src; req_dst = dst; req_len = len; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_req_ready) begin got = 1'b1; break; end
    end
    chk("accepted", got, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish(input int delay, input logic pre, output int n_wr, output int n_rd, output logic err);
    logic got;
    got = 1'b0; n_wr = -1; n_rd = -1; err = 1'bx;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_cmpl_valid) begin got = 1'b1; break; end
    end
    chk("completion_seen", got, 1);
    if (got) begin
      n_wr = obs_wr.size(); n_rd = obs_rd; err = m_cmpl_err;
      repeat (delay) @(posedge clk);
      @(posedge clk); #1;
      cmpl_ready = 1'b1;
      if (pre) req_valid = 1'b1;
      @(posedge clk); #1;
      cmpl_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nw, nr;
    logic er;
    logic got;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", m_req_ready, 1);
    chk("post_reset_busy", m_busy, 0);

    // Basic job, done on first status read
    cfg(-1, 0, -1, 0);
    issue(32'h1000, 32'h2000, 25'd4);
    finish(0, 1'b0, nw, nr, er);
    chk("a_writes", nw, 4);
    chk("a_wr0", obs_wr[0], 32'h1000);
    chk("a_wr1", obs_wr[1], 32'h2000);
    chk("a_wr2", obs_wr[2], 32'h200);
    chk("a_wr3", obs_wr[3], 32'h1);
    chk("a_reads", nr, 1);
    chk("a_err", er, 0);
    chk("a_start_access_latency", start_acc_cyc - accept_cyc, 8);

    // DST write stalled three cycles
    cfg(1, 3, -1, 0);
    issue(32'h1000, 32'h2000, 25'd4);
    finish(0, 1'b0, nw, nr, er);
    chk("b_dst_access_len", acc_log[1], 4);
    chk("b_writes", nw, 4);
    chk("b_err", er, 0);

    // Five not-done polls then done
    cfg(-1, 0, -1, 5);
    issue(32'h1000, 32'h2000, 25'd4);
    finish(0, 1'b0, nw, nr, er);
    chk("c_reads", nr, 6);
    chk("c_gap0", gap_log[0], 16);
    chk("c_gap5", gap_log[5], 16);
    chk("c_err", er, 0);

    // Slave error on LEN; completion held, next request waiting behind it
    cfg(-1, 0, 2, 0);
    issue(32'h1000, 32'h2000, 25'd4);
    req_src = 32'hDEAD_BEE0; req_dst = 32'h0123_4560; req_len = 25'h1FF_FFFF;
    finish(10, 1'b1, nw, nr, er);
    chk("d_writes", nw, 3);
    chk("d_reads", nr, 0);
    chk("d_err", er, 1);
    cfg(-1, 0, -1, 0);
    issue(32'hDEAD_BEE0, 32'h0123_4560, 25'h1FF_FFFF);
    finish(0, 1'b0, nw, nr, er);
    chk("e_len_max", obs_wr[2], 32'hFFFF_FF80);
    chk("e_src", obs_wr[0], 32'hDEAD_BEE0);
    chk("e_err", er, 0);

    // Reset in the middle of the DST access
    cfg(1, 5, -1, 0);
    issue(32'h3000, 32'h4000, 25'd8);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (m_psel && m_penable && m_paddr == BASE_A + 32'h4) begin got = 1'b1; break; end
    end
    chk("f_reached_dst", got, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("f_psel_after_reset", m_psel, 0);
    chk("f_busy_after_reset", m_busy, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("f_no_completion", m_cmpl_valid, 0);

    cfg(-1, 0, -1, 0);
    issue(32'h1000, 32'h2000, 25'd4);
    finish(0, 1'b0, nw, nr, er);
    chk("g_writes", nw, 4);
    chk("g_reads", nr, 1);
    chk("g_err", er, 0);

    // Second driver: poll timeout after MAX_POLLS reads
    sel = 1'b1;
    cfg(-1, 0, -1, 1000);
    issue(32'h0000_8000, 32'h0000_9000, 25'd1);
    finish(0, 1'b0, nw, nr, er);
    chk("h_reads", nr, 4);
    chk("h_err", er, 1);
    chk("h_gap0", gap_log[0], 3);

    // Second driver: done on third read
    cfg(-1, 0, -1, 2);
    issue(32'h0000_A000, 32'h0000_B000, 25'd2);
    finish(0, 1'b0, nw, nr, er);
    chk("i_reads", nr, 3);
    chk("i_err", er, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
